mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single synchronous memory port of the multicycle RV32I core between the core (fetch/load/store traffic) and a debug/loader master. It grants one access per cycle, routes read data back to the owner one cycle later, and prevents debug starvation with a bounded consecutive-grant counter. It sits between the core's memory interface and the on-chip memory.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (core / debug) arbiter for the single synchronous memory port.
// Optional anti-starvation counter enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_CORE = 2'd1,
        RSP_DBG  = 2'd2
    } rsp_state_t;

    rsp_state_t rsp_state_r;
    logic       c_win_s;
    logic       d_win_s;
    logic       hold_hit_s;

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("mem_port_arbiter: MAX_HOLD must be at least 1");
    end

`ifdef ARB_FAIRNESS_EN
    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] hold_cnt_r;

    assign hold_hit_s = (hold_cnt_r == HOLD_MAX);

    // Consecutive core wins while debug waits; any debug win or idle debug clears it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (d_win_s || !d_req) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (c_win_s && !hold_hit_s) begin
            hold_cnt_r <= hold_cnt_r + CNT_ONE;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end
`else
    assign hold_hit_s = 1'b0;
`endif

    // Grant decision; reset masks grants so nothing leaks out while resetn is low.
    always_comb begin
        c_win_s = 1'b0;
        d_win_s = 1'b0;
        if (resetn) begin
            case ({c_req, d_req})
                2'b10: c_win_s = 1'b1;
                2'b01: d_win_s = 1'b1;
                2'b11: begin
                    if (hold_hit_s) begin
                        d_win_s = 1'b1;
                    end else begin
                        c_win_s = 1'b1;
                    end
                end
                default: begin
                    c_win_s = 1'b0;
                    d_win_s = 1'b0;
                end
            endcase
        end else begin
            c_win_s = 1'b0;
            d_win_s = 1'b0;
        end
    end

    assign c_gnt  = c_win_s;
    assign d_gnt  = d_win_s;
    assign mem_en = c_win_s | d_win_s;

    // Memory request mux; an idle port presents all zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (d_win_s) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (c_win_s) begin
            mem_we    = c_we;
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
        end else begin
            mem_we    = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Response owner reloaded every cycle from this cycle's grant, so reads pipeline.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_state_r <= RSP_IDLE;
            c_rvalid    <= 1'b0;
            d_rvalid    <= 1'b0;
            busy        <= 1'b0;
        end else if (c_win_s && !c_we) begin
            rsp_state_r <= RSP_CORE;
            c_rvalid    <= 1'b1;
            d_rvalid    <= 1'b0;
            busy        <= 1'b1;
        end else if (d_win_s && !d_we) begin
            rsp_state_r <= RSP_DBG;
            c_rvalid    <= 1'b0;
            d_rvalid    <= 1'b1;
            busy        <= 1'b1;
        end else begin
            rsp_state_r <= RSP_IDLE;
            c_rvalid    <= 1'b0;
            d_rvalid    <= 1'b0;
            busy        <= 1'b0;
        end
    end

    // Read data steered to the owner recorded in the response state.
    always_comb begin
        c_rdata = {DATA_W{1'b0}};
        d_rdata = {DATA_W{1'b0}};
        case (rsp_state_r)
            RSP_CORE: c_rdata = mem_rdata;
            RSP_DBG:  d_rdata = mem_rdata;
            default: begin
                c_rdata = {DATA_W{1'b0}};
                d_rdata = {DATA_W{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset/starvation sequences and
// random traffic checked against a transaction-level model with a shadow memory.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MH = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] c_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .resetn(resetn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'h1111_1111;
            1:       return 32'h2222_2222;
            2:       return 32'h3333_3333;
            8'h40:   return 32'hDEAD_BEEF;
            default: return 32'hA500_0000 ^ (i * 32'h0001_0203);
        endcase
    endfunction

    // Synchronous memory: loads its image on the first edge, then serves the port.
    logic [31:0] mem_arr [0:255];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr[9:2]];
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    int          pend_owner = 0;     // 0 none, 1 core, 2 debug
    logic [31:0] pend_data = '0;
    int          core_streak = 0;    // core wins in a row while debug waits
    logic        last_cg = 1'b0, last_dg = 1'b0;
    int          errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        logic cwin, dwin;
        @(negedge clk);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        chk("c_rvalid", c_rvalid, pend_owner == 1);
        chk("d_rvalid", d_rvalid, pend_owner == 2);
        chk("c_rdata", c_rdata, (pend_owner == 1) ? pend_data : 32'h0);
        chk("d_rdata", d_rdata, (pend_owner == 2) ? pend_data : 32'h0);
        chk("busy", busy, pend_owner != 0);
        dwin = dr && (!cr || (FAIR && core_streak >= MH));
        cwin = cr && !dwin;
        chk("c_gnt", c_gnt, cwin);
        chk("d_gnt", d_gnt, dwin);
        chk("mem_en", mem_en, cwin | dwin);
        chk("mem_we", mem_we, cwin ? cw : (dwin ? dw : 1'b0));
        chk("mem_addr", mem_addr, cwin ? ca : (dwin ? da : 32'h0));
        chk("mem_wdata", mem_wdata, cwin ? cd : (dwin ? dd : 32'h0));
        pend_owner = 0;
        if (cwin && !cw) begin pend_owner = 1; pend_data = ref_mem[ca[9:2]]; end
        if (dwin && !dw) begin pend_owner = 2; pend_data = ref_mem[da[9:2]]; end
        if (cwin && cw) ref_mem[ca[9:2]] = cd;
        if (dwin && dw) ref_mem[da[9:2]] = dd;
        if (!dr || dwin) core_streak = 0;
        else if (cwin)   core_streak++;
        last_cg = cwin; last_dg = dwin;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_c_gnt"}, c_gnt, 1'b0);
        chk({tag, "_d_gnt"}, d_gnt, 1'b0);
        chk({tag, "_mem_en"}, mem_en, 1'b0);
        chk({tag, "_mem_we"}, mem_we, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_c_rvalid"}, c_rvalid, 1'b0);
        chk({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        chk({tag, "_c_rdata"}, c_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    typedef struct {
        logic cr, cw; logic [31:0] ca, cd;
        logic dr, dw; logic [31:0] da, dd;
        logic ecg, edg, ewe, ecrv, edrv; logic [31:0] erd;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int n, dcount;
        logic        cp, cpw, dp, dpw;
        logic [31:0] cpa, cpd, dpa, dpd;
        cp = 1'b0; dp = 1'b0; cpw = 1'b0; dpw = 1'b0;
        cpa = '0; cpd = '0; dpa = '0; dpd = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        //        cr cw ca       cd            dr dw da     dd            cg dg we crv drv rdata
        tbl[0]  = '{1, 0, 32'h100, 32'h0,         0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,   32'h0,         1, 1, 32'h40, 32'h1234_5678, 0, 1, 1, 1, 0, 32'hDEAD_BEEF};
        tbl[2]  = '{1, 0, 32'h40,  32'h0,         0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0, 32'h0};
        tbl[3]  = '{0, 0, 32'h0,   32'h0,         0, 0, 32'h0, 32'h0,         0, 0, 0, 1, 0, 32'h1234_5678};
        tbl[4]  = '{1, 0, 32'h0,   32'h0,         0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 0, 32'h0};
        tbl[5]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h4, 32'h0,         0, 1, 0, 1, 0, 32'h1111_1111};
        tbl[6]  = '{1, 0, 32'h8,   32'h0,         0, 0, 32'h0, 32'h0,         1, 0, 0, 0, 1, 32'h2222_2222};
        tbl[7]  = '{0, 0, 32'h0,   32'h0,         0, 0, 32'h0, 32'h0,         0, 0, 0, 1, 0, 32'h3333_3333};
        tbl[8]  = '{1, 0, 32'h0,   32'h0,         1, 0, 32'h4, 32'h0,         1, 0, 0, 0, 0, 32'h0};
        tbl[9]  = '{0, 0, 32'h0,   32'h0,         1, 0, 32'h4, 32'h0,         0, 1, 0, 1, 0, 32'h1111_1111};
        tbl[10] = '{0, 0, 32'h0,   32'h0,         0, 0, 32'h0, 32'h0,         0, 0, 0, 0, 1, 32'h2222_2222};
        tbl[11] = '{0, 0, 32'h0,   32'h0,         0, 0, 32'h0, 32'h0,         0, 0, 0, 0, 0, 32'h0};

        // Reset with both requests raised: everything must stay quiet.
        c_req = 1'b1; d_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("por");
        c_req = 1'b0; d_req = 1'b0;
        #1 resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
            chk("tbl_c_gnt", c_gnt, tbl[i].ecg);
            chk("tbl_d_gnt", d_gnt, tbl[i].edg);
            chk("tbl_mem_we", mem_we, tbl[i].ewe);
            chk("tbl_c_rvalid", c_rvalid, tbl[i].ecrv);
            chk("tbl_d_rvalid", d_rvalid, tbl[i].edrv);
            chk("tbl_c_rdata", c_rdata, tbl[i].ecrv ? tbl[i].erd : 32'h0);
            chk("tbl_d_rdata", d_rdata, tbl[i].edrv ? tbl[i].erd : 32'h0);
            chk("tbl_busy", busy, tbl[i].ecrv | tbl[i].edrv);
        end

        // Continuous traffic from both sides; debug holds its request until served.
        n = FAIR ? 20 : 100;
        dcount = 0;
        for (int i = 0; i < n; i++) begin
            apply(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0, 32'h200 + 32'(dcount * 4), 32'h0);
            if (last_dg) dcount++;
        end
        chk("dbg_grants_under_load", 32'(dcount), FAIR ? 32'(n / (MH + 1)) : 32'h0);
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        chk("dbg_gnt_after_core_drop", d_gnt, 1'b1);
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset pulsed right after a core read grant drops the pending response.
        apply(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b0;
        c_req = 1'b1; d_req = 1'b1;
        #1;
        chk_all_zero("rst");
        pend_owner = 0; core_streak = 0;
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        c_req = 1'b0; d_req = 1'b0;
        resetn = 1'b1;
        apply(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("post_rst_c_gnt", c_gnt, 1'b1);
        chk("post_rst_no_stale_rvalid", c_rvalid, 1'b0);

        // Random traffic obeying the hold-until-granted rule.
        for (int i = 0; i < 400; i++) begin
            if (!cp && $urandom_range(0, 3) != 0) begin
                cp = 1'b1; cpw = $urandom_range(0, 2) == 0;
                cpa = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2);
                cpd = $urandom();
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1; dpw = $urandom_range(0, 1) == 0;
                dpa = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 255)) << 2);
                dpd = $urandom();
            end
            apply(cp, cpw, cpa, cpd, dp, dpw, dpa, dpd);
            if (last_cg) cp = 1'b0;
            if (last_dg) dp = 1'b0;
        end
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
